// File: rtl/fetch_unit.sv
// Instruction prefetch stage: owns the program counter, keeps a small FIFO of
// prefetched words and hands the next word to IR on each ir_load pulse.
module fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ir_load,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_addr,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ack,
    input  logic [31:0]             mem_rdata,
    output logic [31:0]             IR,
    output logic [ADDR_W-1:0]       ir_pc,
    output logic                    ir_valid,
    output logic                    fetch_stall,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       queue [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_nxt;
    logic [ADDR_W-1:0] next_pc;
    logic              pending;
    logic              accept;
    logic              take;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              issue;
    logic              launch;

    // A word is usable only if it completes a BUSY fetch not cancelled by a redirect.
    always_comb begin
        accept = (state != IDLE) && mem_ack;
        take   = accept && (state == BUSY) && !redirect_valid;
        bypass = take && (pending || (ir_load && (count == '0)));
        push   = take && !bypass;
        pop    = ir_load && !redirect_valid && !pending && (count != '0);
        if (redirect_valid) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        end
        if (redirect_valid) begin
            fetch_pc_nxt = redirect_addr;
        end else if (take) begin
            fetch_pc_nxt = fetch_pc + ADDR_W'(1);
        end else begin
            fetch_pc_nxt = fetch_pc;
        end
        issue = count_nxt < CNT_W'(DEPTH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Back-to-back requests are launched on the edge that completes the previous one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue) state_nxt = BUSY;
            end
            BUSY: begin
                if (accept) begin
                    state_nxt = issue ? BUSY : IDLE;
                end else if (redirect_valid) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (accept) state_nxt = issue ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state != IDLE);
        launch  = (state_nxt == BUSY) && ((state == IDLE) || accept);
    end

    always_ff @(posedge clock) begin
        if (push) queue[tail] <= mem_rdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            next_pc  <= RESET_PC;
            mem_addr <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            IR       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            pending  <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            count    <= count_nxt;
            if (launch) mem_addr <= fetch_pc_nxt;
            if (redirect_valid) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop) head <= head + PTR_W'(1);
            end
            // A load arriving with a redirect stays pending for the new stream.
            if (redirect_valid) begin
                next_pc  <= redirect_addr;
                ir_valid <= 1'b0;
                pending  <= pending | ir_load;
            end else if (pop || bypass) begin
                IR       <= pop ? queue[head] : mem_rdata;
                ir_pc    <= next_pc;
                next_pc  <= next_pc + ADDR_W'(1);
                ir_valid <= 1'b1;
                pending  <= 1'b0;
            end else if (ir_load && (count == '0)) begin
                pending <= 1'b1;
            end
        end
    end

    assign fetch_stall = pending;
    assign q_count     = count;

endmodule
